// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. Adds two WIDTH-bit operands plus a
// carry-in, LSB first, one bit per clock through a single full-adder slice
// and a carry flop. Throughput is one addition per WIDTH+1 cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (aborts any operation in flight)
//   start  - request; only looked at when busy=0 (IDLE or DONE)
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   sub    - (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b
//   busy   - high while bits are being processed
//   done   - one-cycle pulse; sum/cout valid
//   sum    - result, held from done until the next completion
//   cout   - carry-out (with sub: 1 = no borrow), held with sum
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             c;
    logic             s;
    logic             c_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder slice on the current LSBs; the sum bit enters the result MSB.
    always_comb begin
        s        = a_sr[0] ^ b_sr[0] ^ c;
        c_next   = maj(a_sr[0], b_sr[0], c);
        res_next = res >> 1;
        res_next[WIDTH-1] = s;
    end

    // Subtraction is a + ~b + 1, so only the B load and carry load change.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE for back-to-back use.
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        c     <= c_load;
                        cnt   <= '0;
                        state <= ADD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ADD: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= c_next;
                    res  <= res_next;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish the result including the bit just formed.
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= c_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] held_sum  = 8'h00;
    logic       held_cout = 1'b0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expected result per done pulse; sum/cout must hold while busy.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e[7:0]});
                check("cout", {31'd0, cout}, {31'd0, e[8]});
                held_sum  = e[7:0];
                held_cout = e[8];
            end
        end else if (busy) begin
            check("sum_hold", {23'd0, cout, sum}, {23'd0, held_cout, held_sum});
        end
    end

    // Drives one request; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                         input logic [7:0] es, input logic ec, input bit push);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        if (push) exp_q.push_back({ec, es});
        @(posedge clk);
        #1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges since acceptance (starting from n0) until done; bounded.
    task automatic wait_done(input int n0, output int n, output int busyc);
        n = n0;
        busyc = 1;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) busyc++;
            if (n >= 40) begin
                check("done_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int n, bc, edges, dn, last, cnt_done;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0 + 0
        issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1);
        wait_done(0, n, bc);
        check("latency_zero", n, 32'd8);
        check("busy_cycles", bc, 32'd8);

        // 0xFF + 0x01 wraps with carry out
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1);
        wait_done(0, n, bc);
        check("latency_ff01", n, 32'd8);

        // 0x7F + 0x80 + 1 = 0x100
        issue(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1);
        wait_done(0, n, bc);

        // Back-to-back with start held high: period WIDTH+1
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 8'h46});
        edges = 0; dn = 0; last = -1;
        while (dn < 3 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                dn++;
                if (last >= 0) check("b2b_period", edges - last, 32'd9);
                last = edges;
                if (dn == 3) start = 1'b0;
            end
        end
        check("b2b_count", dn, 32'd3);

        // Start with a=0xAA mid-ADD must be ignored
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);
        @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h12;
        wait_done(2, n, bc);
        check("latency_ignore", n, 32'd8);
        repeat (12) @(negedge clk);
        check("ignore_no_extra", exp_q.size(), 32'd0);

        // Operand change after acceptance: 0x10 + 0x05
        issue(8'h10, 8'h05, 1'b0, 8'h15, 1'b0, 1);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        wait_done(0, n, bc);

        // Reset during the 4th ADD cycle aborts
        issue(8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        held_sum = 8'h00;
        held_cout = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("abort_no_done", cnt_done, 32'd0);
        issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1);
        wait_done(0, n, bc);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        issue(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1);
        wait_done(0, n, bc);
        check("latency_sub", n, 32'd8);
        issue(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1);
        wait_done(0, n, bc);
        sub = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
